// File: rtl/enemy_fire_scheduler.sv
// Enemy bullet scheduler: shares one bullet between enemy columns, launching from the
// front ship of the next eligible column. Optional macro ENEMY_FIRE_LFSR_EN picks the start column pseudo-randomly.
module enemy_fire_scheduler #(
  parameter int unsigned num_cols_p          = 8,
  parameter int unsigned fire_delay_frames_p = 60,
  parameter logic [9:0]  bullet_step_p       = 10'd4,
  parameter logic [9:0]  screen_bot_p        = 10'd479
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       frame_i,
  input  logic                       start_i,
  input  logic                       stop_i,
  input  logic [num_cols_p-1:0]      col_valid_i,
  input  logic [10*num_cols_p-1:0]   col_x_i,
  input  logic [10*num_cols_p-1:0]   col_bot_i,
  input  logic                       bullet_clear_i,
  output logic                       fire_o,
  output logic [3:0]                 fire_col_o,
  output logic                       bullet_active_o,
  output logic [9:0]                 bullet_x_o,
  output logic [9:0]                 bullet_y_o
);

  localparam int unsigned coord_w = 10;
  localparam int unsigned idx_w   = 4;
  localparam int unsigned cnt_w   = $clog2(fire_delay_frames_p + 1);
  localparam logic [cnt_w-1:0] cnt_last = cnt_w'(fire_delay_frames_p - 1);
  localparam logic [idx_w-1:0] idx_last = idx_w'(num_cols_p - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_SELECT,
    ST_FLIGHT
  } state_t;

  state_t               state_q, state_d;
  logic [cnt_w-1:0]     cnt_q, cnt_d;
  logic                 fire_q, fire_d;
  logic [idx_w-1:0]     fire_col_q, fire_col_d;
  logic                 active_q, active_d;
  logic [coord_w-1:0]   x_q, x_d;
  logic [coord_w-1:0]   y_q, y_d;

  logic [idx_w-1:0]     start_idx;
  logic                 hit;
  logic                 hi_hit;
  logic [idx_w-1:0]     hi_idx;
  logic [idx_w-1:0]     lo_idx;
  logic [idx_w-1:0]     sel_idx;
  logic [idx_w-1:0]     sel_next;
  logic [coord_w-1:0]   sel_x;
  logic [coord_w-1:0]   sel_y;
  logic [coord_w:0]     y_next;

`ifdef ENEMY_FIRE_LFSR_EN
  logic [15:0] lfsr_q;
  logic        lfsr_fb;

  assign lfsr_fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign start_idx = idx_w'(32'(lfsr_q[3:0]) % num_cols_p);

  // Free-running start-column generator, stepped once per frame
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lfsr_q <= 16'hACE1;
    end else if (frame_i) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_fb};
    end
  end
`else
  logic [idx_w-1:0] ptr_q, ptr_d;

  assign start_idx = ptr_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Wrapping priority search: lowest live column at/after start, else lowest overall
  always_comb begin
    hit    = 1'b0;
    hi_hit = 1'b0;
    hi_idx = '0;
    lo_idx = '0;
    for (int i = int'(num_cols_p) - 1; i >= 0; i--) begin
      if (col_valid_i[i]) begin
        hit    = 1'b1;
        lo_idx = idx_w'(i);
        if (idx_w'(i) >= start_idx) begin
          hi_hit = 1'b1;
          hi_idx = idx_w'(i);
        end
      end
    end
    sel_idx  = hi_hit ? hi_idx : lo_idx;
    sel_next = (sel_idx == idx_last) ? '0 : idx_w'(sel_idx + idx_w'(1));
  end

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < int'(num_cols_p); i++) begin
      if (idx_w'(i) == sel_idx) begin
        sel_x = col_x_i[i*coord_w +: coord_w];
        sel_y = col_bot_i[i*coord_w +: coord_w];
      end
    end
  end

  // One extra bit so the off-screen test cannot wrap
  assign y_next = {1'b0, y_q} + {1'b0, bullet_step_p};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      fire_q     <= 1'b0;
      fire_col_q <= '0;
      active_q   <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fire_q     <= fire_d;
      fire_col_q <= fire_col_d;
      active_q   <= active_d;
      x_q        <= x_d;
      y_q        <= y_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fire_d     = 1'b0;
    fire_col_d = fire_col_q;
    active_d   = active_q;
    x_d        = x_q;
    y_d        = y_q;
`ifndef ENEMY_FIRE_LFSR_EN
    ptr_d      = ptr_q;
`endif
    if (stop_i) begin
      state_d  = ST_IDLE;
      active_d = 1'b0;
      cnt_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
        ST_WAIT: begin
          if (frame_i) begin
            if (cnt_q == cnt_last) begin
              state_d = ST_SELECT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + cnt_w'(1);
            end
          end
        end
        ST_SELECT: begin
          if (hit) begin
            state_d    = ST_FLIGHT;
            fire_d     = 1'b1;
            active_d   = 1'b1;
            fire_col_d = sel_idx;
            x_d        = sel_x;
            y_d        = sel_y;
`ifndef ENEMY_FIRE_LFSR_EN
            ptr_d      = sel_next;
`endif
          end else begin
            state_d = ST_WAIT;
            cnt_d   = '0;
          end
        end
        ST_FLIGHT: begin
          // A hit retires the bullet in place, ahead of any movement this cycle
          if (bullet_clear_i) begin
            state_d  = ST_WAIT;
            active_d = 1'b0;
            cnt_d    = '0;
          end else if (frame_i) begin
            if (y_next > {1'b0, screen_bot_p}) begin
              state_d  = ST_WAIT;
              active_d = 1'b0;
              cnt_d    = '0;
            end else begin
              y_d = y_next[coord_w-1:0];
            end
          end
        end
        default: begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
          cnt_d    = '0;
        end
      endcase
    end
  end

  assign fire_o          = fire_q;
  assign fire_col_o      = fire_col_q;
  assign bullet_active_o = active_q;
  assign bullet_x_o      = x_q;
  assign bullet_y_o      = y_q;

endmodule
